// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for mul_div_unit.
//   OP_MUL / OP_DIV : opSelect encodings accepted by the unit.
//   state_e         : control FSM states (IDLE, RUN, DONE).
// Optional feature macro used by the unit: MULDIV_DIV_EN (division datapath).
package muldiv_pkg;

    localparam logic [5:0] OP_MUL = 6'b001000;
    localparam logic [5:0] OP_DIV = 6'b001001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes.
// The next dividend bit (MSB of i_quo) is shifted into the partial remainder, the divisor
// is trial-subtracted, and the resulting quotient bit enters the LSB of the quotient word.
// Only instantiated when MULDIV_DIV_EN is defined.
// Ports:
//   i_rem     partial remainder (always < divisor)
//   i_quo     dividend bits still to consume (MSB first) / quotient bits so far (LSB side)
//   i_divisor divisor magnitude, non-zero
//   o_rem     next partial remainder
//   o_quo     i_quo shifted left with the new quotient bit appended
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_qbit;

    // One extra bit so a negative trial result shows up in the MSB.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_qbit  = ~w_diff[WIDTH];
    assign o_rem   = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_qbit};

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiplier (radix-2 Booth) and optional restoring divider.
// Optional feature macro: MULDIV_DIV_EN -- compiles in the DIV datapath and divZero.
// Without it, OP_DIV is rejected like any other unknown opcode and divZero is 0.
// Ports:
//   Clock     sole clock, rising edge
//   clear     asynchronous active-low reset
//   start     request, sampled on rising edge when not busy
//   opSelect  OP_MUL or OP_DIV (others ignored)
//   opA, opB  multiplicand/dividend, multiplier/divisor
//   resLo     product low half / quotient
//   resHi     product high half / remainder
//   busy      high exactly while in RUN
//   finished  results valid (level, held in DONE)
//   divZero   last DIV had a zero divisor
// A command accepted at edge E0 spends WIDTH iteration edges plus one finalize edge in RUN,
// so finished rises on edge E(WIDTH+1). The results registers only load on that edge.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [5:0]       opSelect,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] resLo,
    output logic [WIDTH-1:0] resHi,
    output logic             busy,
    output logic             finished,
    output logic             divZero
);

    localparam int unsigned    CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH);

    state_e           r_state;
    logic [CW-1:0]    r_count;
    // MUL: {r_acc, r_q, r_qm1} is the Booth register; r_acc has two guard bits so A +/- M
    // never overflows. DIV: r_acc low half is the partial remainder, r_q the dividend/quotient.
    logic [WIDTH+1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH:0]   r_mcand;
    logic             r_bmsb;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_busy;
    logic             r_finished;

    logic             w_op_mul;
    logic             w_op_div;
    logic             w_accept;
    logic [WIDTH:0]   w_mcand_ext;
    logic [WIDTH+1:0] w_m_ext;
    logic [WIDTH+1:0] w_booth_sum;
    logic [WIDTH+1:0] w_b_acc;
    logic [WIDTH-1:0] w_b_q;
    logic             w_b_qm1;
    logic [WIDTH-1:0] w_mul_hi;

    assign w_op_mul = (opSelect == OP_MUL);
`ifdef MULDIV_DIV_EN
    assign w_op_div = (opSelect == OP_DIV);
`else
    assign w_op_div = 1'b0;
`endif
    assign w_accept = start && (r_state != RUN) && (w_op_mul || w_op_div);

    // Multiplicand widened by one bit: sign bit when signed, zero when unsigned.
    assign w_mcand_ext = {SIGNED_EN & opA[WIDTH-1], opA};
    assign w_m_ext     = {r_mcand[WIDTH], r_mcand};

    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q-1}.
    assign w_b_acc = {w_booth_sum[WIDTH+1], w_booth_sum[WIDTH+1:1]};
    assign w_b_q   = {w_booth_sum[0], r_q[WIDTH-1:1]};
    assign w_b_qm1 = r_q[0];

    // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set was
    // weighted -2^(W-1) instead of +2^(W-1), so add M back into the high half.
    assign w_mul_hi = r_acc[WIDTH-1:0]
                    + ((!SIGNED_EN && r_bmsb) ? r_mcand[WIDTH-1:0] : '0);

`ifdef MULDIV_DIV_EN
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_rem_fin;

    assign w_a_neg = SIGNED_EN & opA[WIDTH-1];
    assign w_b_neg = SIGNED_EN & opB[WIDTH-1];
    // Magnitude of the most-negative value wraps to 2^(W-1), which is correct unsigned.
    assign w_a_mag = w_a_neg ? -opA : opA;
    assign w_b_mag = w_b_neg ? -opB : opB;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[WIDTH-1:0]),
        .i_quo     (r_q),
        .i_divisor (r_mcand[WIDTH-1:0]),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // MIN / -1 gives magnitude 2^(W-1), whose negation is MIN again.
    assign w_quo_fin = r_neg_q ? -r_q : r_q;
    assign w_rem_fin = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign divZero   = r_div_zero;
`else
    assign divZero   = 1'b0;
`endif

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_qm1      <= 1'b0;
            r_mcand    <= '0;
            r_bmsb     <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_finished <= 1'b0;
                        r_count    <= '0;
                        r_bmsb     <= opB[WIDTH-1];
`ifdef MULDIV_DIV_EN
                        r_div_zero <= 1'b0;
                        r_is_div   <= w_op_div;
`endif
                        if (w_op_div) begin
`ifdef MULDIV_DIV_EN
                            if (opB == '0) begin
                                r_state    <= DONE;
                                r_finished <= 1'b1;
                                r_div_zero <= 1'b1;
                                r_res_lo   <= '1;
                                r_res_hi   <= opA;
                            end else begin
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                                r_acc   <= '0;
                                r_q     <= w_a_mag;
                                r_mcand <= {1'b0, w_b_mag};
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                            end
`endif
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_acc   <= '0;
                            r_q     <= opB;
                            r_qm1   <= 1'b0;
                            r_mcand <= w_mcand_ext;
                        end
                    end
                end
                RUN: begin
                    if (r_count == LAST_STEP) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_res_lo   <= r_q;
                        r_res_hi   <= w_mul_hi;
`ifdef MULDIV_DIV_EN
                        if (r_is_div) begin
                            r_res_lo <= w_quo_fin;
                            r_res_hi <= w_rem_fin;
                        end
`endif
                    end else begin
                        r_count <= r_count + CW'(1);
                        r_acc   <= w_b_acc;
                        r_q     <= w_b_q;
                        r_qm1   <= w_b_qm1;
`ifdef MULDIV_DIV_EN
                        if (r_is_div) begin
                            r_acc <= {2'b00, w_div_rem};
                            r_q   <= w_div_quo;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign resLo    = r_res_lo;
    assign resHi    = r_res_hi;
    assign busy     = r_busy;
    assign finished = r_finished;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit. Two instances share all inputs:
// dut_s (SIGNED_EN=1) and dut_u (SIGNED_EN=0). Expected results come from a plain
// arithmetic model. DIV checks depend on MULDIV_DIV_EN being defined for the build.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         clear;
    logic         start;
    logic [5:0]   opSelect;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] lo_s, hi_s, lo_u, hi_u;
    logic         busy_s, fin_s, dz_s, busy_u, fin_u, dz_u;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
        .Clock(Clock), .clear(clear), .start(start), .opSelect(opSelect), .opA(opA), .opB(opB),
        .resLo(lo_s), .resHi(hi_s), .busy(busy_s), .finished(fin_s), .divZero(dz_s)
    );

    mul_div_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .Clock(Clock), .clear(clear), .start(start), .opSelect(opSelect), .opA(opA), .opB(opB),
        .resLo(lo_u), .resHi(hi_u), .busy(busy_u), .finished(fin_u), .divZero(dz_u)
    );

    // Reference result {divZero, resHi, resLo}.
    function automatic logic [2*W:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input bit sgn);
        longint      sp;
        logic [63:0] p;
        int          sa, sb, q, r;
        logic [31:0] q32, r32;
        if (op == OP_MUL) begin
            if (sgn) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
            end else begin
                p = {32'h0, a} * {32'h0, b};
            end
            return {1'b0, p};
        end
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
            sa  = a;
            sb  = b;
            q   = sa / sb;
            r   = sa % sb;
            q32 = q;
            r32 = r;
            return {1'b0, r32, q32};
        end
        return {1'b0, a % b, a / b};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    // Issues one command and waits (bounded) for finished on both instances.
    // run_ok: busy high and results frozen until finished, busy low afterwards.
    task automatic do_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int repulse_at, output int edges, output bit run_ok,
                         output bit fin_at_e0);
        logic [W-1:0] lo0, hi0, lou0, hiu0;
        @(negedge Clock);
        opSelect = op;
        opA      = a;
        opB      = b;
        start    = 1'b1;
        @(posedge Clock);
        #1;
        start     = 1'b0;
        opA       = $urandom;
        opB       = $urandom;
        fin_at_e0 = fin_s;
        lo0 = lo_s; hi0 = hi_s; lou0 = lo_u; hiu0 = hi_u;
        edges  = 0;
        run_ok = 1'b1;
        while (!(fin_s && fin_u) && edges < 200) begin
            if (!busy_s || !busy_u || lo_s !== lo0 || hi_s !== hi0 || lo_u !== lou0 ||
                hi_u !== hiu0) run_ok = 1'b0;
            if (edges == repulse_at) begin
                start    = 1'b1;
                opSelect = OP_MUL;
                opA      = $urandom;
                opB      = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge Clock);
            #1;
            edges++;
        end
        start = 1'b0;
        if (busy_s || busy_u || fin_s !== fin_u) run_ok = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0; start = 1'b0; opSelect = OP_MUL; opA = '0; opB = '0;
        #1;
        checks++;
        if ({lo_s, hi_s, busy_s, fin_s, dz_s} !== '0) begin
            errors++;
            $display("FAIL reset_signed got %h/%h b%0b f%0b z%0b want all 0",
                     lo_s, hi_s, busy_s, fin_s, dz_s);
        end
        checks++;
        if ({lo_u, hi_u, busy_u, fin_u, dz_u} !== '0) begin
            errors++;
            $display("FAIL reset_unsigned got %h/%h b%0b f%0b z%0b want all 0",
                     lo_u, hi_u, busy_u, fin_u, dz_u);
        end
        @(negedge Clock);
        clear = 1'b1;
    endtask

    task automatic test_mul_directed();
        int edges; bit ok, f0;
        do_op(OP_MUL, 32'h1000_000F, 32'h0000_0020, -1, edges, ok, f0);
        checks++;
        if ({hi_s, lo_s} !== 64'h0000_0002_0000_01E0 || {hi_u, lo_u} !== 64'h0000_0002_0000_01E0)
        begin
            errors++;
            $display("FAIL mul_directed_1 got %h%h / %h%h want 00000002000001e0",
                     hi_s, lo_s, hi_u, lo_u);
        end
        checks++;
        if (edges != 33 || !ok) begin
            errors++;
            $display("FAIL mul_latency got %0d edges run_ok=%0b want 33 run_ok=1", edges, ok);
        end
        do_op(OP_MUL, 32'hFFFF_FFFD, 32'h5, -1, edges, ok, f0);
        checks++;
        if ({hi_s, lo_s} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            errors++;
            $display("FAIL mul_signed_neg got %h%h want fffffffffffffff1", hi_s, lo_s);
        end
        checks++;
        if ({hi_u, lo_u} !== 64'h0000_0004_FFFF_FFF1) begin
            errors++;
            $display("FAIL mul_unsigned got %h%h want 00000004fffffff1", hi_u, lo_u);
        end
    endtask

    task automatic test_mul_random();
        int edges; bit ok, f0;
        logic [W-1:0] a, b;
        logic [2*W:0] es, eu;
        for (int i = 0; i < 16; i++) begin
            a = pick();
            b = pick();
            do_op(OP_MUL, a, b, -1, edges, ok, f0);
            es = model(OP_MUL, a, b, 1'b1);
            eu = model(OP_MUL, a, b, 1'b0);
            checks++;
            if ({dz_s, hi_s, lo_s} !== es) begin
                errors++;
                $display("FAIL mul_rand_s a=%h b=%h got %h want %h", a, b, {dz_s, hi_s, lo_s}, es);
            end
            checks++;
            if ({dz_u, hi_u, lo_u} !== eu) begin
                errors++;
                $display("FAIL mul_rand_u a=%h b=%h got %h want %h", a, b, {dz_u, hi_u, lo_u}, eu);
            end
            checks++;
            if (edges != 33 || !ok) begin
                errors++;
                $display("FAIL mul_rand_timing got %0d edges run_ok=%0b want 33/1", edges, ok);
            end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int edges; bit ok, f0;
        logic [W-1:0] a, b;
        logic [2*W:0] es, eu;
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        va = '{32'd100, 32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000};
        vb = '{32'd7,   32'd2,         32'h0,         32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) begin
            a = (i < 4) ? va[i] : pick();
            b = (i < 4) ? vb[i] : pick();
            do_op(OP_DIV, a, b, -1, edges, ok, f0);
            es = model(OP_DIV, a, b, 1'b1);
            eu = model(OP_DIV, a, b, 1'b0);
            checks++;
            if ({dz_s, hi_s, lo_s} !== es) begin
                errors++;
                $display("FAIL div_s a=%h b=%h got %h want %h", a, b, {dz_s, hi_s, lo_s}, es);
            end
            checks++;
            if ({dz_u, hi_u, lo_u} !== eu) begin
                errors++;
                $display("FAIL div_u a=%h b=%h got %h want %h", a, b, {dz_u, hi_u, lo_u}, eu);
            end
            checks++;
            if (edges != ((b == 0) ? 0 : 33) || !ok) begin
                errors++;
                $display("FAIL div_timing b=%h got %0d edges run_ok=%0b want %0d/1",
                         b, edges, ok, (b == 0) ? 0 : 33);
            end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [W-1:0] lo0, hi0;
        logic         f0;
        lo0 = lo_s; hi0 = hi_s; f0 = fin_s;
        @(negedge Clock);
        opSelect = OP_DIV; opA = 32'h1234; opB = '0; start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (busy_s !== 1'b0 || busy_u !== 1'b0 || fin_s !== f0 || dz_s !== 1'b0 ||
            lo_s !== lo0 || hi_s !== hi0) begin
            errors++;
            $display("FAIL div_disabled got b%0b/%0b f%0b z%0b %h/%h want b0/0 f%0b z0 %h/%h",
                     busy_s, busy_u, fin_s, dz_s, lo_s, hi_s, f0, lo0, hi0);
        end
    endtask
`endif

    task automatic test_invalid_op();
        logic [5:0]   op;
        logic [W-1:0] lo0, hi0;
        logic         f0;
        for (int i = 0; i < 4; i++) begin
            do op = 6'($urandom); while (op == OP_MUL || op == OP_DIV);
            lo0 = lo_s; hi0 = hi_s; f0 = fin_s;
            @(negedge Clock);
            opSelect = op; opA = $urandom; opB = $urandom; start = 1'b1;
            @(posedge Clock);
            #1;
            start = 1'b0;
            repeat (2) @(posedge Clock);
            #1;
            checks++;
            if (busy_s !== 1'b0 || busy_u !== 1'b0 || fin_s !== f0 || lo_s !== lo0 ||
                hi_s !== hi0) begin
                errors++;
                $display("FAIL invalid_op op=%b got b%0b f%0b %h/%h want b0 f%0b %h/%h",
                         op, busy_s, fin_s, lo_s, hi_s, f0, lo0, hi0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges; bit ok, f0;
        logic [W-1:0] a, b;
        do_op(OP_MUL, 32'd3, 32'd4, -1, edges, ok, f0);
        a = $urandom;
        b = $urandom;
        do_op(OP_MUL, a, b, -1, edges, ok, f0);
        checks++;
        if (f0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_finished_drop got %0b want 0", f0);
        end
        checks++;
        if ({dz_s, hi_s, lo_s} !== model(OP_MUL, a, b, 1'b1) || edges != 33 || !ok) begin
            errors++;
            $display("FAIL b2b_result got %h edges=%0d want %h edges=33",
                     {dz_s, hi_s, lo_s}, edges, model(OP_MUL, a, b, 1'b1));
        end
    endtask

    task automatic test_busy_ignore();
        int edges; bit ok, f0;
        logic [W-1:0] a, b;
        a = $urandom;
        b = $urandom;
        do_op(OP_MUL, a, b, 10, edges, ok, f0);
        checks++;
        if ({dz_s, hi_s, lo_s} !== model(OP_MUL, a, b, 1'b1) ||
            {dz_u, hi_u, lo_u} !== model(OP_MUL, a, b, 1'b0)) begin
            errors++;
            $display("FAIL busy_ignore_result got %h/%h want %h/%h", {hi_s, lo_s}, {hi_u, lo_u},
                     model(OP_MUL, a, b, 1'b1), model(OP_MUL, a, b, 1'b0));
        end
        checks++;
        if (edges != 33 || !ok) begin
            errors++;
            $display("FAIL busy_ignore_timing got %0d edges run_ok=%0b want 33/1", edges, ok);
        end
    endtask

    task automatic test_clear_mid_run();
        int edges;
        @(negedge Clock);
        opSelect = OP_MUL; opA = $urandom; opB = $urandom; start = 1'b1;
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        clear = 1'b0;
        opA   = 32'd6;
        opB   = 32'd7;
        #1;
        checks++;
        if ({lo_s, hi_s, busy_s, fin_s, dz_s, lo_u, hi_u, busy_u, fin_u, dz_u} !== '0) begin
            errors++;
            $display("FAIL clear_async got %h/%h b%0b f%0b want all 0", lo_s, hi_s, busy_s, fin_s);
        end
        @(posedge Clock);
        #1;
        checks++;
        if ({lo_s, hi_s, busy_s, fin_s, dz_s} !== '0) begin
            errors++;
            $display("FAIL clear_held got %h/%h b%0b f%0b want all 0", lo_s, hi_s, busy_s, fin_s);
        end
        @(negedge Clock);
        clear = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (busy_s !== 1'b1 || busy_u !== 1'b1) begin
            errors++;
            $display("FAIL clear_first_edge_accept got b%0b/%0b want 1/1", busy_s, busy_u);
        end
        start = 1'b0;
        edges = 0;
        while (!fin_s && edges < 200) begin
            @(posedge Clock);
            #1;
            edges++;
        end
        checks++;
        if ({hi_s, lo_s} !== 64'd42 || {hi_u, lo_u} !== 64'd42 || edges != 33) begin
            errors++;
            $display("FAIL clear_then_mul got %h%h edges=%0d want 42 edges=33", hi_s, lo_s, edges);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul_directed();
        test_mul_random();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_invalid_op();
        test_back_to_back();
        test_busy_ignore();
        test_clear_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width, even, >= 4.
REQ-002 Parameter SIGNED_EN, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on rising edge.
REQ-006 opSelect  input  6  operation; MUL = 6'b001000, DIV = 6'b001001; other codes are rejected.
REQ-007 opA  input  WIDTH  multiplicand / dividend (RY side).
REQ-008 opB  input  WIDTH  multiplier / divisor (bus side).
REQ-009 resLo  output  WIDTH  product low half / quotient.
REQ-010 resHi  output  WIDTH  product high half / remainder.
REQ-011 busy  output  1  operation in progress.
REQ-012 finished  output  1  result valid; level signal.
REQ-013 divZero  output  1  last DIV had divisor zero.

Function
REQ-014 The FSM shall have three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 with a valid opSelect shall latch opA, opB and opSelect, clear finished and divZero, load count=0, and go to RUN.
REQ-016 In IDLE or DONE, start=1 with an invalid opSelect shall be ignored, with no state change.
REQ-017 start shall be ignored while busy=1; the latched operands shall not change.
REQ-018 MUL shall use radix-2 Booth: one step per cycle, WIDTH steps, 2*WIDTH-bit product {resHi,resLo}.
REQ-019 DIV shall use restoring division on magnitudes: one quotient bit per cycle, WIDTH steps.
REQ-020 Signed DIV shall truncate the quotient toward zero, and the remainder shall take the dividend's sign.
REQ-021 Signed DIV of the most-negative value by -1 shall give resLo = most-negative value and resHi = 0.
REQ-022 DIV with opB = 0 shall skip RUN and go to DONE on the next edge, with resLo = all ones, resHi = opA, divZero = 1.
REQ-023 Latency: when start is sampled at edge E0, finished shall rise after edge E(WIDTH+1) and results shall be valid at the same time.
REQ-024 busy shall be 1 exactly while in RUN.
REQ-025 finished and the results shall hold in DONE until the next accepted start.
REQ-026 resLo and resHi shall not change while in RUN; intermediate values stay internal.
REQ-027 A new start accepted in DONE shall drop finished on that same edge.

Reset
REQ-028 clear=0 shall force, asynchronously and at any time including mid-RUN, state IDLE, count 0, resLo = 0, resHi = 0, busy = 0, finished = 0, divZero = 0.
REQ-029 After clear is released, the first rising edge shall be able to accept start.

Configuration
REQ-030 Macro MULDIV_DIV_EN, when defined, shall compile in the DIV datapath and the divZero logic.
REQ-031 Without MULDIV_DIV_EN, the DIV opcode shall be treated as invalid per REQ-016, and divZero shall be tied to 0.

Structure
REQ-032 Package muldiv_pkg shall hold the opSelect encodings (OP_MUL, OP_DIV) and the state enum (IDLE, RUN, DONE).
REQ-033 Sub-module div_step shall be a combinational single restoring step (shift, trial subtract, quotient bit), instantiated only under MULDIV_DIV_EN.

Verification
REQ-034 MUL 0x1000000F x 0x00000020 -> resHi = 0x00000002, resLo = 0x000001E0; finished rises 33 edges after start.
REQ-035 Signed MUL -3 x 5 -> resHi = 0xFFFFFFFF, resLo = 0xFFFFFFF1; with SIGNED_EN = 0, 0xFFFFFFFD x 5 -> resHi = 0x00000004, resLo = 0xFFFFFFF1.
REQ-036 DIV 100 / 7 -> resLo = 14, resHi = 2; DIV -7 / 2 -> resLo = 0xFFFFFFFD, resHi = 0xFFFFFFFF.
REQ-037 DIV 0x1234 / 0 -> next edge: finished = 1, divZero = 1, resLo = 0xFFFFFFFF, resHi = 0x00001234; without the macro -> ignored, busy stays 0.
REQ-038 clear pulsed low 10 cycles into a MUL, with start held high throughout -> all outputs 0 immediately; after release a fresh MUL 6 x 7 -> resLo = 42, resHi = 0.
REQ-039 start re-pulsed mid-RUN with different operands -> the original result is delivered, with unchanged latency.
